fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the instruction cache.
- Drives the cache's two read ports (x/y) with the current and next PC and consumes the registered hit/instruction responses.
- Byte-swaps each returned word into program order and buffers up to QUEUE_DEPTH instructions, with their PCs, for decode.
- Handles branch redirects with a full flush.

Parameters:
- QUEUE_DEPTH, 8, instruction queue entries; power of 2, >= 4.
- QPTR_WIDTH, 3, log2(QUEUE_DEPTH).
- RESET_PC, 32'h0, first fetch address after reset.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- rdy  input  1  global enable; low = stall
- redirect  input  1  one-cycle pulse: flush and restart fetch
- redirect_pc  input  32  new fetch address; bits [1:0] ignored
- en_rx  output  1  x-port request valid
- pcx  output  32  x-port address
- en_ry  output  1  y-port request valid
- pcy  output  32  y-port address, pcx+4
- hitx  input  1  x-port hit, registered, for the previous cycle's pcx
- instx  input  32  x-port word; first memory byte in [31:24]
- hity  input  1  y-port hit
- insty  input  32  y-port word
- inst_valid  output  1  queue head valid
- inst_out  output  32  head instruction, program byte order
- inst_pc  output  32  head PC
- inst_ready  input  1  decode pops the head when inst_valid && inst_ready
- qcount  output  QPTR_WIDTH+1  occupied entries

Behaviour:
- Reset state (rst high):
  - fetch_pc = RESET_PC; head, tail and count = 0; req_valid = 0.
  - en_rx = en_ry = 0; inst_valid = 0; qcount = 0.
  - pcx = RESET_PC; pcy = RESET_PC+4.
- Stall (rdy low): all state held except req_valid, which clears (the cache invalidates itself on ~rdy). en_rx = en_ry = 0. No push, no pop.
- Response acceptance:
  - accept = req_valid && hitx && !redirect.
  - accept2 = accept && hity (dual mode only).
  - A response is attributed to the PC registered as req_pc in the previous cycle.
- Push rules:
  - On accept, push {swap(instx), req_pc}.
  - On accept2, also push {swap(insty), req_pc+4} in the following slot.
  - swap: out[7:0] = in[31:24], out[15:8] = in[23:16], out[23:16] = in[15:8], out[31:24] = in[7:0].
  - A y-hit without an x-hit is discarded. No out-of-order push.
- Next-PC logic (combinational):
  - next_pc = req_pc+8 if accept2; req_pc+4 if accept; otherwise fetch_pc.
  - pcx = next_pc; fetch_pc <= next_pc each active cycle.
  - This gives one bundle per cycle on a hit streak.
  - On a miss, the same PC is re-requested every cycle until it hits.
- Issue rule:
  - en_rx = rdy && !rst && !redirect && (count + pushes - pop) <= QUEUE_DEPTH-2.
  - pushes = 0, 1 or 2 for this cycle; pop = 1 if a pop happens this cycle.
  - en_ry = en_rx in dual mode.
  - req_valid <= en_rx; req_pc <= pcx.
  - This margin guarantees an accepted response never overflows the queue. No push occurs when req_valid = 0.
- Redirect (highest priority, any cycle including a stall cycle with rdy high):
  - head = tail = count = 0.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}; req_valid <= 0.
  - Same-cycle response and pop are dropped; inst_valid is 0 from the next cycle.
  - First new request is issued the cycle after redirect.
- Queue:
  - Circular; pointers wrap modulo QUEUE_DEPTH.
  - Same-cycle pop + push(1|2) is allowed; count updates by pushes-pop.
  - inst_out and inst_pc are read combinationally at head. inst_valid = (count != 0).
  - Pop while empty is ignored.
- Arithmetic: all PC arithmetic is 32-bit unsigned; wrap at 2^32 is allowed, no flag.

Optional Feature:
- Macro: FETCH_DUAL_EN.
- Defined: y-port is used; up to 2 pushes per cycle; issue margin is QUEUE_DEPTH-2.
- Undefined: en_ry = 0, pcy = 0; hity and insty are ignored; accept2 = 0; issue margin is count+pushes-pop <= QUEUE_DEPTH-1; max 1 push per cycle.

Test Plan:
- Reset, RESET_PC=0; hitx=1 on every cycle from cycle 1 with instx=32'h13000000; dual off; inst_ready=1 -> inst_out=32'h00000013, inst_pc = 0, 4, 8, ... on consecutive cycles.
- Dual on; hitx=hity=1; instx=32'h93000010, insty=32'h13010020; inst_ready=0 -> queue pushes PCs 0 and 4 in one cycle; inst_out=32'h10000093; qcount caps at 8 with en_rx=0 once count >= 6.
- Miss then hit: hitx=0 for 3 cycles at pcx=32'h40 -> pcx holds 32'h40, no push; hitx=1 on the 4th cycle -> push at pc 32'h40, pcx becomes 32'h44.
- Redirect pulse with redirect_pc=32'h1003 while qcount=5 and hitx=1 -> that hit is not pushed; next cycle qcount=0, inst_valid=0, pcx=32'h1000.
- rdy low for 2 cycles mid-stream with hitx=1 -> no push, no pop, qcount held; the response after rdy returns is accepted only after a fresh request; first push pc = held fetch_pc.
- Full boundary, dual off, DEPTH=8: count=7, pop and accept in the same cycle -> count stays 7; tail wraps from 7 to 0 correctly.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the I-cache x/y read ports and buffers byte-swapped words.
// Define FETCH_DUAL_EN to use the y-port (up to two instructions per cycle).
module fetch_unit #(
    parameter int unsigned QUEUE_DEPTH = 8,
    parameter int unsigned QPTR_WIDTH  = 3,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  redirect,
    input  logic [31:0]           redirect_pc,
    output logic                  en_rx,
    output logic [31:0]           pcx,
    output logic                  en_ry,
    output logic [31:0]           pcy,
    input  logic                  hitx,
    input  logic [31:0]           instx,
    input  logic                  hity,
    input  logic [31:0]           insty,
    output logic                  inst_valid,
    output logic [31:0]           inst_out,
    output logic [31:0]           inst_pc,
    input  logic                  inst_ready,
    output logic [QPTR_WIDTH:0]   qcount
);

`ifdef FETCH_DUAL_EN
    localparam int unsigned MARGIN = QUEUE_DEPTH - 2;
`else
    localparam int unsigned MARGIN = QUEUE_DEPTH - 1;
`endif
    localparam int unsigned CW = QPTR_WIDTH + 2;

    logic [31:0]           fetch_pc_q;
    logic [31:0]           req_pc_q;
    logic                  req_valid_q;
    logic [QPTR_WIDTH-1:0] head_q;
    logic [QPTR_WIDTH-1:0] tail_q;
    logic [QPTR_WIDTH:0]   count_q;
    logic [31:0]           q_inst [QUEUE_DEPTH];
    logic [31:0]           q_pc   [QUEUE_DEPTH];

    logic          active;
    logic          accept;
    logic          accept2;
    logic          pop;
    logic [CW-1:0] n_push;
    logic [CW-1:0] count_next;
    logic [31:0]   next_pc;

    // Cache returns the first memory byte in [31:24]; decode wants it in [7:0].
    function automatic logic [31:0] swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    always_comb begin
        active  = rdy && !rst && !redirect;
        accept  = active && req_valid_q && hitx;
`ifdef FETCH_DUAL_EN
        accept2 = accept && hity;
`else
        accept2 = 1'b0;
`endif
        pop        = active && (count_q != '0) && inst_ready;
        n_push     = CW'(accept) + CW'(accept2);
        count_next = CW'(count_q) + n_push - CW'(pop);
        if (accept2) begin
            next_pc = req_pc_q + 32'd8;
        end else if (accept) begin
            next_pc = req_pc_q + 32'd4;
        end else begin
            next_pc = fetch_pc_q;
        end
    end

    // Only issue if the response could be pushed without overflowing the queue.
    always_comb begin
        pcx        = rst ? RESET_PC : next_pc;
        en_rx      = active && (count_next <= CW'(MARGIN));
`ifdef FETCH_DUAL_EN
        en_ry      = en_rx;
        pcy        = pcx + 32'd4;
`else
        en_ry      = 1'b0;
        pcy        = 32'h0;
`endif
        inst_valid = (count_q != '0);
        inst_out   = q_inst[head_q];
        inst_pc    = q_pc[head_q];
        qcount     = count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q  <= RESET_PC;
            req_pc_q    <= RESET_PC;
            req_valid_q <= 1'b0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
        end else if (redirect) begin
            fetch_pc_q  <= {redirect_pc[31:2], 2'b00};
            req_valid_q <= 1'b0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
        end else if (!rdy) begin
            // The cache drops its pending response on a stall, so the request is lost.
            req_valid_q <= 1'b0;
        end else begin
            fetch_pc_q  <= next_pc;
            req_pc_q    <= pcx;
            req_valid_q <= en_rx;
            head_q      <= head_q + QPTR_WIDTH'(pop);
            tail_q      <= tail_q + QPTR_WIDTH'(n_push);
            count_q     <= count_next[QPTR_WIDTH:0];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            q_inst[tail_q] <= swap(instx);
            q_pc[tail_q]   <= req_pc_q;
        end
        if (accept2) begin
            q_inst[tail_q + QPTR_WIDTH'(1)] <= swap(insty);
            q_pc[tail_q + QPTR_WIDTH'(1)]   <= req_pc_q + 32'd4;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{redirect_pc[1:0], hity, insty};

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based reference model plus directed scenarios.
module tb_fetch_unit;

    localparam int DEPTH = 8;
`ifdef FETCH_DUAL_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        en_rx;
    logic [31:0] pcx;
    logic        en_ry;
    logic [31:0] pcy;
    logic        hitx;
    logic [31:0] instx;
    logic        hity;
    logic [31:0] insty;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic [3:0]  qcount;

    int checks = 0;
    int errors = 0;

    fetch_unit #(
        .QUEUE_DEPTH (8),
        .QPTR_WIDTH  (3),
        .RESET_PC    (32'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .en_rx       (en_rx),
        .pcx         (pcx),
        .en_ry       (en_ry),
        .pcy         (pcy),
        .hitx        (hitx),
        .instx       (instx),
        .hity        (hity),
        .insty       (insty),
        .inst_valid  (inst_valid),
        .inst_out    (inst_out),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready),
        .qcount      (qcount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: the queue is a list of (instruction, pc) pairs.
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    entry_t      mq[$];
    logic [31:0] m_fetch;
    logic [31:0] m_req_pc;
    bit          m_req_valid;
    bit          started;
    bit          e_acc;
    bit          e_acc2;
    bit          e_pop;
    bit          e_en;
    int          e_push;
    logic [31:0] e_next;
    logic [31:0] e_pcx;

    function automatic logic [31:0] byte_rev(input logic [31:0] w);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = w[8*(3-b) +: 8];
        return r;
    endfunction

    task automatic eval_model();
        bit act;
        act    = (rdy === 1'b1) && (rst === 1'b0) && (redirect === 1'b0);
        e_acc  = act && m_req_valid && (hitx === 1'b1);
        e_acc2 = DUAL && e_acc && (hity === 1'b1);
        e_pop  = act && (mq.size() > 0) && (inst_ready === 1'b1);
        e_push = int'(e_acc) + int'(e_acc2);
        e_next = e_acc2 ? m_req_pc + 32'd8 : (e_acc ? m_req_pc + 32'd4 : m_fetch);
        e_pcx  = (rst === 1'b1) ? 32'h0 : e_next;
        e_en   = act && (mq.size() + e_push - int'(e_pop) <= DEPTH - (DUAL ? 2 : 1));
    endtask

    // Inputs are stable from posedge+1 to the next posedge, so compare and advance at negedge.
    initial begin
        started     = 1'b0;
        m_req_valid = 1'b0;
        m_fetch     = 32'h0;
        m_req_pc    = 32'h0;
        forever begin
            @(negedge clk);
            eval_model();
            if (started) begin
                chk("en_rx", en_rx, e_en);
                chk("pcx", pcx, e_pcx);
                chk("en_ry", en_ry, DUAL ? e_en : 1'b0);
                chk("pcy", pcy, DUAL ? e_pcx + 32'd4 : 32'h0);
                chk("inst_valid", inst_valid, mq.size() > 0);
                chk("qcount", qcount, mq.size());
                if (mq.size() > 0) begin
                    chk("inst_out", inst_out, mq[0].inst);
                    chk("inst_pc", inst_pc, mq[0].pc);
                end
            end
            if (rst === 1'b1) begin
                started     = 1'b1;
                m_fetch     = 32'h0;
                m_req_valid = 1'b0;
                mq.delete();
            end else if (redirect === 1'b1) begin
                m_fetch     = {redirect_pc[31:2], 2'b00};
                m_req_valid = 1'b0;
                mq.delete();
            end else if (rdy !== 1'b1) begin
                m_req_valid = 1'b0;
            end else begin
                if (e_pop) void'(mq.pop_front());
                if (e_acc) mq.push_back('{byte_rev(instx), m_req_pc});
                if (e_acc2) mq.push_back('{byte_rev(insty), m_req_pc + 32'd4});
                m_fetch     = e_next;
                m_req_valid = e_en;
                m_req_pc    = e_pcx;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; rdy = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
        hitx = 1'b1; instx = 32'h13000000; hity = 1'b0; insty = 32'h0; inst_ready = 1'b1;
        @(negedge clk);
        chk("rst_en_rx", en_rx, 1'b0);
        chk("rst_qcount", qcount, 4'd0);
        chk("rst_inst_valid", inst_valid, 1'b0);
        chk("rst_pcx", pcx, 32'h0);

        // Single-issue hit streak
        cyc(); rst = 1'b0;
        @(negedge clk); chk("c0_pcx", pcx, 32'h0); chk("c0_en_rx", en_rx, 1'b1);
        cyc(); @(negedge clk); chk("c1_valid", inst_valid, 1'b0); chk("c1_pcx", pcx, 32'h4);
        cyc(); @(negedge clk);
        chk("c2_valid", inst_valid, 1'b1);
        chk("c2_inst", inst_out, 32'h00000013);
        chk("c2_pc", inst_pc, 32'h0);
        cyc(); @(negedge clk); chk("c3_pc", inst_pc, 32'h4);
        cyc(); @(negedge clk); chk("c4_pc", inst_pc, 32'h8);
        repeat (10) cyc();

        // Miss then hit at 0x40
        redirect = 1'b1; redirect_pc = 32'h40; hitx = 1'b0; inst_ready = 1'b0;
        cyc(); redirect = 1'b0;
        cyc(); @(negedge clk); chk("miss1_pcx", pcx, 32'h40); chk("miss1_q", qcount, 4'd0);
        cyc(); @(negedge clk); chk("miss2_pcx", pcx, 32'h40); chk("miss2_q", qcount, 4'd0);
        cyc(); hitx = 1'b1; instx = 32'hdeadbeef;
        @(negedge clk); chk("hit_pcx", pcx, 32'h44);
        cyc(); @(negedge clk);
        chk("hit_q", qcount, 4'd1);
        chk("hit_pc", inst_pc, 32'h40);
        chk("hit_inst", inst_out, 32'hefbeadde);

        // Redirect with a live hit and five queued entries
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (qcount == 4'd5) break;
        end
        chk("reach_q5", qcount, 4'd5);
        redirect = 1'b1; redirect_pc = 32'h1003;
        @(negedge clk); chk("redir_en_rx", en_rx, 1'b0);
        cyc(); redirect = 1'b0; inst_ready = 1'b1; instx = 32'h13000000;
        @(negedge clk);
        chk("redir_q", qcount, 4'd0);
        chk("redir_valid", inst_valid, 1'b0);
        chk("redir_pcx", pcx, 32'h1000);

        // Two-cycle stall mid-stream
        repeat (3) cyc();
        cyc(); rdy = 1'b0;
        @(negedge clk); chk("stall_en_rx", en_rx, 1'b0); chk("stall_q", qcount, 4'd1);
        cyc(); @(negedge clk); chk("stall2_q", qcount, 4'd1); chk("stall2_pc", inst_pc, 32'h1008);
        cyc(); rdy = 1'b1;
        @(negedge clk); chk("resume_pcx", pcx, 32'h100c); chk("resume_en_rx", en_rx, 1'b1);
        cyc(); @(negedge clk); chk("resume_valid", inst_valid, 1'b0);
        cyc(); @(negedge clk); chk("resume_pc", inst_pc, 32'h100c);

        // Near-full: pop and accept in the same cycle, pointers wrap
        cyc(); inst_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (qcount == 4'd7) break;
        end
        chk("reach_q7", qcount, 4'd7);
        inst_ready = 1'b1;
`ifndef FETCH_DUAL_EN
        @(negedge clk); chk("full_en_rx", en_rx, 1'b1);
        cyc(); @(negedge clk); chk("full_q_hold", qcount, 4'd7);
`endif
        repeat (10) cyc();

        // Dual-port stream into a stalled decoder
        redirect = 1'b1; redirect_pc = 32'h0; hitx = 1'b1; hity = 1'b1;
        instx = 32'h93000010; insty = 32'h13010020; inst_ready = 1'b0;
        cyc(); redirect = 1'b0;
        cyc();
        cyc(); @(negedge clk);
        chk("dual_inst", inst_out, 32'h10000093);
        chk("dual_pc", inst_pc, 32'h0);
`ifdef FETCH_DUAL_EN
        chk("dual_q2", qcount, 4'd2);
        repeat (4) cyc();
        @(negedge clk); chk("dual_q8", qcount, 4'd8); chk("dual_en_rx", en_rx, 1'b0);
        repeat (3) cyc();
        @(negedge clk); chk("dual_q8_hold", qcount, 4'd8);
`else
        chk("single_q1", qcount, 4'd1);
        chk("single_en_ry", en_ry, 1'b0);
        chk("single_pcy", pcy, 32'h0);
        repeat (8) cyc();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
